// File: rtl/regfile_sequencer.sv
`timescale 1ns/1ps
// Register-file command sequencer: runs bit-serial read (through an external
// serial ALU) and write phases against a 32x32 register file, one bit per cycle.
module regfile_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        ready,
    input  logic [1:0]  mode,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [31:0] wdata,
    input  logic        portA,
    input  logic        portB,
    input  logic        aluBit,
    output logic        aluEn,
    output logic        aluFirst,
    output logic [4:0]  regA_select,
    output logic [4:0]  regB_select,
    output logic [4:0]  bitPos,
    output logic        writeEn,
    output logic        data_in,
    output logic        done,
    output logic [31:0] rdata
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRead  = 2'd1;
    localparam logic [1:0] StWrite = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [1:0] ModeRr  = 2'b00;
    localparam logic [1:0] ModeRd  = 2'b01;
    localparam logic [1:0] ModeWr  = 2'b10;

    logic [1:0]  state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [4:0]  rs1_q, rs1_d;
    logic [4:0]  rs2_q, rs2_d;
    logic [4:0]  rd_q, rd_d;
    logic [4:0]  bit_pos_q, bit_pos_d;
    logic [31:0] buffer_q, buffer_d;

    logic [4:0]  sel_a_q, sel_a_d;
    logic [4:0]  sel_b_q, sel_b_d;
    logic        write_en_q, write_en_d;
    logic        data_in_q, data_in_d;
    logic        alu_en_q, alu_en_d;
    logic        alu_first_q, alu_first_d;
    logic        done_q, done_d;

    // Sequencing: command acceptance, per-bit capture and phase transitions.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        bit_pos_d = bit_pos_q;
        buffer_d  = buffer_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d    = mode;
                    rs1_d     = rs1;
                    rs2_d     = rs2;
                    rd_d      = rd;
                    bit_pos_d = 5'd0;
                    case (mode)
                        ModeRr, ModeRd: state_d = StRead;
                        ModeWr: begin
                            buffer_d = wdata;
                            state_d  = (rd != 5'd0) ? StWrite : StDone;
                        end
                        default: state_d = StDone;
                    endcase
                end
            end
            StRead: begin
                // portA/aluBit are combinational on the current bitPos/selects.
                buffer_d[bit_pos_q] = (mode_q == ModeRr) ? aluBit : portA;
                if (bit_pos_q == 5'd31) begin
                    bit_pos_d = 5'd0;
                    state_d   = (mode_q == ModeRr && rd_q != 5'd0) ? StWrite : StDone;
                end else begin
                    bit_pos_d = bit_pos_q + 5'd1;
                end
            end
            StWrite: begin
                if (bit_pos_q == 5'd31) begin
                    bit_pos_d = 5'd0;
                    state_d   = StDone;
                end else begin
                    bit_pos_d = bit_pos_q + 5'd1;
                end
            end
            default: begin
                bit_pos_d = 5'd0;
                state_d   = StIdle;
            end
        endcase
    end

    // Register-file outputs decoded from the next state so they appear registered.
    always_comb begin
        sel_a_d     = 5'd0;
        sel_b_d     = 5'd0;
        write_en_d  = 1'b0;
        data_in_d   = 1'b0;
        alu_en_d    = 1'b0;
        alu_first_d = 1'b0;
        done_d      = 1'b0;
        case (state_d)
            StRead: begin
                sel_a_d     = rs1_d;
                sel_b_d     = rs2_d;
                alu_en_d    = 1'b1;
                alu_first_d = (bit_pos_d == 5'd0);
            end
            StWrite: begin
                sel_a_d    = rd_d;
                // r0 is never a write target, even if WRITE were reached with rd=0.
                write_en_d = (rd_d != 5'd0);
                data_in_d  = buffer_d[bit_pos_d];
            end
            StDone:  done_d = 1'b1;
            default: ;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            mode_q      <= 2'b00;
            rs1_q       <= 5'd0;
            rs2_q       <= 5'd0;
            rd_q        <= 5'd0;
            bit_pos_q   <= 5'd0;
            buffer_q    <= 32'd0;
            sel_a_q     <= 5'd0;
            sel_b_q     <= 5'd0;
            write_en_q  <= 1'b0;
            data_in_q   <= 1'b0;
            alu_en_q    <= 1'b0;
            alu_first_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            bit_pos_q   <= bit_pos_d;
            buffer_q    <= buffer_d;
            sel_a_q     <= sel_a_d;
            sel_b_q     <= sel_b_d;
            write_en_q  <= write_en_d;
            data_in_q   <= data_in_d;
            alu_en_q    <= alu_en_d;
            alu_first_q <= alu_first_d;
            done_q      <= done_d;
        end
    end

    assign ready       = (state_q == StIdle);
    assign regA_select = sel_a_q;
    assign regB_select = sel_b_q;
    assign bitPos      = bit_pos_q;
    assign writeEn     = write_en_q;
    assign data_in     = data_in_q;
    assign aluEn       = alu_en_q;
    assign aluFirst    = alu_first_q;
    assign done        = done_q;
    assign rdata       = buffer_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
`timescale 1ns/1ps
// Bench for regfile_sequencer: emulates the serial register file and adder,
// and checks results against a word-level model of the register file.
module tb_regfile_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ready;
    logic [1:0]  mode;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] wdata;
    logic        portA, portB, aluBit;
    logic        aluEn, aluFirst;
    logic [4:0]  regA_select, regB_select, bitPos;
    logic        writeEn, data_in, done;
    logic [31:0] rdata;

    regfile_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ready       (ready),
        .mode        (mode),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .wdata       (wdata),
        .portA       (portA),
        .portB       (portB),
        .aluBit      (aluBit),
        .aluEn       (aluEn),
        .aluFirst    (aluFirst),
        .regA_select (regA_select),
        .regB_select (regB_select),
        .bitPos      (bitPos),
        .writeEn     (writeEn),
        .data_in     (data_in),
        .done        (done),
        .rdata       (rdata)
    );

    always #5 clk = ~clk;

    // Environment: bit-serial register file and ripple adder.
    logic [31:0] rf [32] = '{default: 32'd0};
    logic        carry;
    logic        cin;

    assign portA  = rf[regA_select][bitPos];
    assign portB  = rf[regB_select][bitPos];
    assign cin    = aluFirst ? 1'b0 : carry;
    assign aluBit = portA ^ portB ^ cin;

    always @(posedge clk or posedge rst) begin
        if (rst) carry <= 1'b0;
        else if (aluEn) carry <= (portA & portB) | (cin & (portA ^ portB));
    end

    always @(posedge clk) begin
        if (writeEn) rf[regA_select][bitPos] <= data_in;
    end

    // Word-level reference model.
    logic [31:0] exp_rf [32] = '{default: 32'd0};
    logic [31:0] exp_rdata = 32'd0;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one command and follow it to its done pulse. With hold=1, start stays
    // high (mode switched to NOP) to confirm only one command runs until done.
    task automatic run_cmd(input logic [1:0] m, input logic [4:0] a, input logic [4:0] b,
                           input logic [4:0] d, input logic [31:0] w, input bit hold);
        logic [31:0] exp_val;
        int exp_lat, exp_we, exp_af;
        int k, we_cnt, af_cnt, rd0_we, din_err, busy_ready;
        exp_val = 32'd0;
        exp_lat = 2;
        exp_we  = 0;
        exp_af  = 0;
        case (m)
            2'b00: begin
                exp_val = exp_rf[a] + exp_rf[b];
                exp_lat = (d != 0) ? 66 : 34;
                exp_we  = (d != 0) ? 32 : 0;
                exp_af  = 1;
                exp_rdata = exp_val;
                if (d != 0) exp_rf[d] = exp_val;
            end
            2'b01: begin
                exp_val = exp_rf[a];
                exp_lat = 34;
                exp_af  = 1;
                exp_rdata = exp_val;
            end
            2'b10: begin
                exp_val = w;
                exp_lat = (d != 0) ? 34 : 2;
                exp_we  = (d != 0) ? 32 : 0;
                exp_rdata = w;
                if (d != 0) exp_rf[d] = w;
            end
            default: ;
        endcase
        check_eq("ready_before", {31'd0, ready}, 32'd1);
        start = 1'b1; mode = m; rs1 = a; rs2 = b; rd = d; wdata = w;
        @(posedge clk); #1;
        if (hold) begin
            mode = 2'b11;
        end else begin
            start = 1'b0;
            mode = 2'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
            rd = 5'($urandom); wdata = $urandom;
        end
        k = 1; we_cnt = 0; af_cnt = 0; rd0_we = 0; din_err = 0; busy_ready = 0;
        while (done !== 1'b1 && k < 200) begin
            if (writeEn) begin
                we_cnt++;
                if (regA_select == 5'd0) rd0_we++;
                if (regA_select != d || data_in !== exp_val[bitPos]) din_err++;
            end
            if (aluFirst) af_cnt++;
            if (ready) busy_ready++;
            @(posedge clk); #1;
            k++;
        end
        check_eq("latency", k + 1, exp_lat);
        check_eq("we_cycles", we_cnt, exp_we);
        check_eq("alu_first", af_cnt, exp_af);
        check_eq("we_r0", rd0_we, 0);
        check_eq("write_bits", din_err, 0);
        check_eq("ready_busy", busy_ready, 0);
        check_eq("we_in_done", {31'd0, writeEn}, 32'd0);
        check_eq("rdata", rdata, exp_rdata);
        check_eq("rf_rd", rf[d], exp_rf[d]);
        @(posedge clk); #1;
        check_eq("done_pulse", {31'd0, done}, 32'd0);
        check_eq("ready_after", {31'd0, ready}, 32'd1);
        if (hold) begin
            @(posedge clk); #1;
            check_eq("held_second", {31'd0, done}, 32'd1);
            start = 1'b0;
            check_eq("held_rdata", rdata, exp_rdata);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int dn;
        logic [31:0] w;
        rst = 1'b1; start = 1'b0; mode = 2'b11; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        wdata = 32'd0;
        #2;
        check_eq("rst_ready", {31'd0, ready}, 32'd1);
        check_eq("rst_we", {31'd0, writeEn}, 32'd0);
        check_eq("rst_alu", {30'd0, aluEn, aluFirst}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_din", {31'd0, data_in}, 32'd0);
        check_eq("rst_sel", {17'd0, regA_select, regB_select, bitPos}, 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_cmd(2'b10, 5'd0, 5'd0, 5'd5, 32'hA5A5_1234, 1'b0);
        run_cmd(2'b01, 5'd5, 5'd0, 5'd0, 32'd0, 1'b0);
        run_cmd(2'b10, 5'd0, 5'd0, 5'd5, 32'hFFFF_FFFF, 1'b0);
        run_cmd(2'b10, 5'd0, 5'd0, 5'd6, 32'h0000_0001, 1'b0);
        run_cmd(2'b00, 5'd5, 5'd6, 5'd7, 32'd0, 1'b0);
        run_cmd(2'b01, 5'd7, 5'd0, 5'd0, 32'd0, 1'b0);
        run_cmd(2'b00, 5'd5, 5'd5, 5'd0, 32'd0, 1'b0);
        run_cmd(2'b10, 5'd0, 5'd0, 5'd0, 32'h1357_9BDF, 1'b0);
        run_cmd(2'b11, 5'd0, 5'd0, 5'd0, 32'hDEAD_BEEF, 1'b0);
        run_cmd(2'b00, 5'd6, 5'd6, 5'd6, 32'd0, 1'b0);
        run_cmd(2'b00, 5'd5, 5'd6, 5'd8, 32'd0, 1'b1);

        // Reset in the middle of a write phase.
        start = 1'b1; mode = 2'b10; rd = 5'd9; wdata = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!(writeEn && bitPos == 5'd10) && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq("mid_write_pos", {27'd0, bitPos}, 32'd10);
        #2 rst = 1'b1;
        #1;
        check_eq("rstw_we", {31'd0, writeEn}, 32'd0);
        check_eq("rstw_ready", {31'd0, ready}, 32'd1);
        check_eq("rstw_rdata", rdata, 32'd0);
        check_eq("rstw_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rdata = 32'd0;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dn++;
            @(posedge clk); #1;
        end
        check_eq("rstw_no_done", dn, 0);
        run_cmd(2'b10, 5'd0, 5'd0, 5'd9, 32'h0BAD_F00D, 1'b0);

        for (int i = 0; i < 40; i++) begin
            w = $urandom;
            run_cmd(2'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), 5'($urandom), w, 1'b0);
        end

        for (int i = 0; i < 32; i++) check_eq("rf_final", rf[i], exp_rf[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sequencer.md
REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: start  in  1  command request; accepted when start && ready.
REQ-004 SHALL have port: ready  out  1  high only in IDLE.
REQ-005 SHALL have port: mode  in  2  00 RR (read rs1/rs2, write ALU result to rd), 01 RD (read rs1), 10 WR (write wdata to rd), 11 NOP.
REQ-006 SHALL have ports: rs1, rs2, rd  in  5 each  register indices, sampled at acceptance.
REQ-007 SHALL have port: wdata  in  32  write value for WR, sampled at acceptance.
REQ-008 SHALL have ports: portA, portB  in  1 each  register-file serial read bits, combinational for current selects/bitPos.
REQ-009 SHALL have port: aluBit  in  1  serial ALU result bit, combinational from portA/portB.
REQ-010 SHALL have ports: aluEn, aluFirst  out  1 each  ALU step enable; first-bit (carry clear) marker.
REQ-011 SHALL have ports: regA_select, regB_select, bitPos  out  5 each  register-file addressing.
REQ-012 SHALL have ports: writeEn, data_in  out  1 each  register-file write strobe and bit.
REQ-013 SHALL have ports: done  out  1 (one-cycle pulse); rdata  out  32 (result buffer).

Function
REQ-014 SHALL implement states IDLE, READ, WRITE, DONE; all register-file outputs registered.
REQ-015 IDLE: writeEn=0, aluEn=0, selects=0, bitPos=0; start ignored in every other state.
REQ-016 On acceptance (cycle T), SHALL latch mode, rs1, rs2, rd; WR also loads buffer<=wdata.
REQ-017 Next state from IDLE: RR/RD -> READ; WR -> WRITE if rd!=0 else DONE; NOP -> DONE.
REQ-018 READ: 32 cycles, bitPos 0..31 ascending, regA_select=rs1, regB_select=rs2, writeEn=0, aluEn=1, aluFirst=1 only at bitPos=0.
REQ-019 READ capture: each edge buffer[bitPos] <= aluBit (RR) or portA (RD).
REQ-020 After bitPos=31 in READ: RR with rd!=0 -> WRITE; RR with rd=0 or RD -> DONE.
REQ-021 WRITE: 32 cycles, bitPos 0..31, regA_select=rd, regB_select=0, writeEn=1, data_in=buffer[bitPos], aluEn=0; after bitPos=31 -> DONE.
REQ-022 bitPos SHALL reset to 0 on every READ/WRITE entry; no wrap past 31 within a phase.
REQ-023 DONE: exactly one cycle, done=1, writeEn=0, rdata=buffer; then IDLE.
REQ-024 rdata SHALL hold until the next accepted command alters the buffer; NOP leaves buffer unchanged.
REQ-025 Latency start->done: RR 66 cycles, RD 34, WR 34, RR/WR with rd=0 34/2, NOP 2.
REQ-026 rs1=rd or rs2=rd SHALL be legal (read completes before write).
REQ-027 SHALL never assert writeEn with rd=0 selected.

Reset
REQ-028 rst SHALL immediately force IDLE, ready=1, writeEn=0, aluEn=0, aluFirst=0, done=0, data_in=0, selects=0, bitPos=0, buffer/rdata=0.
REQ-029 rst mid-WRITE SHALL drop writeEn asynchronously; partially written rd acceptable; no done pulse.

Verification
REQ-030 WR rd=5, wdata=0xA5A5_1234 -> 32 writeEn cycles, regA_select=5, data_in = wdata LSB-first; done at T+34.
REQ-031 RD rs1=5 after REQ-030 -> rdata=0xA5A5_1234, done at T+34, writeEn never high.
REQ-032 RR add rs1=5 (0xFFFF_FFFF), rs2=6 (0x1), rd=7 -> aluFirst once, r7 reads 0x0000_0000, done at T+66.
REQ-033 RR rd=0 and WR rd=0 -> writeEn never asserted, done at T+34 and T+2.
REQ-034 start held high during RR -> only one command accepted; second accepted in the cycle after done.
REQ-035 rst asserted at WRITE bitPos=10 -> writeEn low same cycle, ready=1, rdata=0, no done.
